// File: rtl/mod_unit_pkg.sv
// mod_unit_pkg: shared widths and FSM encoding for the sequential modulo unit.
//   A_W_DEF / B_W_DEF / C_W_DEF : default dividend, divisor and result widths.
//   CNT_W_DEF                   : bit-counter width for the default dividend width.
//   state_t                     : controller states IDLE -> RUN -> FIN -> IDLE.
package mod_unit_pkg;

  localparam int A_W_DEF   = 17;
  localparam int B_W_DEF   = 5;
  localparam int C_W_DEF   = 10;
  localparam int CNT_W_DEF = $clog2(A_W_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/mod_unit_step.sv
// mod_unit_step: one combinational restoring shift-subtract step.
//   rem_in  : partial remainder so far (always < b)
//   bit_in  : next dividend bit, MSB first
//   b       : divisor (non-zero while stepping)
//   rem_out : new partial remainder, still < b
module mod_unit_step
  import mod_unit_pkg::*;
#(
  parameter int B_W = B_W_DEF
) (
  input  logic [B_W-1:0] rem_in,
  input  logic           bit_in,
  input  logic [B_W-1:0] b,
  output logic [B_W-1:0] rem_out
);

  // One extra bit holds the shifted value, which may reach 2*b-1.
  logic [B_W:0] shifted_s;

  // Shift the next dividend bit in and subtract the divisor when it fits.
  always_comb begin
    shifted_s = {rem_in, bit_in};
    if (shifted_s >= {1'b0, b}) begin
      // Result is < b, so dropping the top bit loses nothing.
      rem_out = B_W'(shifted_s - {1'b0, b});
    end else begin
      rem_out = shifted_s[B_W-1:0];
    end
  end

endmodule

// File: rtl/mod_unit.sv
// mod_unit: sequential unsigned modulo, c = a mod b, one dividend bit per clock.
//   clk         : rising-edge clock
//   rst_n       : synchronous active-low reset
//   start       : request pulse, only sampled while idle
//   a, b        : dividend / divisor, captured when start is accepted
//   busy        : high while an operation is in flight
//   done        : one-cycle pulse; c and div_by_zero are valid from this cycle
//   c           : zero-extended remainder (truncated dividend when b == 0)
//   div_by_zero : set when the last completed operation had b == 0
// All outputs come straight from registers.
module mod_unit
  import mod_unit_pkg::*;
#(
  parameter int A_W = A_W_DEF,
  parameter int B_W = B_W_DEF,
  parameter int C_W = C_W_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  output logic           busy,
  output logic           done,
  output logic [C_W-1:0] c,
  output logic           div_by_zero
);

  localparam int             CNT_W    = $clog2(A_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(A_W - 1);

  state_t           state_r, state_s;
  // Dividend is kept as a left-shifting register: its MSB is the next bit to consume.
  logic [A_W-1:0]   a_r, a_s;
  logic [B_W-1:0]   b_r, b_s;
  logic [B_W-1:0]   rem_r, rem_s;
  logic [B_W-1:0]   rem_step_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic [C_W-1:0]   c_r, c_s;
  logic             dbz_r, dbz_s;

  mod_unit_step #(
    .B_W (B_W)
  ) u_step (
    .rem_in  (rem_r),
    .bit_in  (a_r[A_W-1]),
    .b       (b_r),
    .rem_out (rem_step_s)
  );

  // Next-state and next-output logic for the IDLE/RUN/FIN controller.
  always_comb begin
    state_s = state_r;
    a_s     = a_r;
    b_s     = b_r;
    rem_s   = rem_r;
    cnt_s   = cnt_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
    c_s     = c_r;
    dbz_s   = dbz_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          a_s    = a;
          b_s    = b;
          rem_s  = {B_W{1'b0}};
          cnt_s  = CNT_LAST;
          busy_s = 1'b1;
          // A zero divisor skips the loop; FIN reports the truncated dividend.
          if (b == {B_W{1'b0}}) begin
            state_s = FIN;
          end else begin
            state_s = RUN;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        rem_s = rem_step_s;
        a_s   = {a_r[A_W-2:0], 1'b0};
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_s = FIN;
        end else begin
          cnt_s   = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          state_s = RUN;
        end
      end
      FIN: begin
        done_s  = 1'b1;
        busy_s  = 1'b0;
        state_s = IDLE;
        if (b_r == {B_W{1'b0}}) begin
          // a_r was never shifted on this path, so it still holds the dividend.
          c_s   = C_W'(a_r);
          dbz_s = 1'b1;
        end else begin
          c_s   = C_W'(rem_r);
          dbz_s = 1'b0;
        end
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      a_r     <= {A_W{1'b0}};
      b_r     <= {B_W{1'b0}};
      rem_r   <= {B_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      c_r     <= {C_W{1'b0}};
      dbz_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      a_r     <= a_s;
      b_r     <= b_s;
      rem_r   <= rem_s;
      cnt_r   <= cnt_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      c_r     <= c_s;
      dbz_r   <= dbz_s;
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign c           = c_r;
  assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_mod_unit.sv
// tb_mod_unit: directed-vector bench for mod_unit with a transaction-level
// model (accepted operations, completion edge, held result) checked every cycle.
module tb_mod_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [16:0] a;
  logic [4:0]  b;
  logic        busy;
  logic        done;
  logic [9:0]  c;
  logic        div_by_zero;

  int vectors     = 0;
  int miscompares = 0;

  // Model state: edge counter, one pending operation, result held after done.
  int         edge_n    = 0;
  int         done_edge = -1;
  int         done_at   = -1;
  bit         pend      = 1'b0;
  logic [9:0] exp_c     = 10'd0;
  bit         exp_dbz   = 1'b0;
  logic [9:0] held_c    = 10'd0;
  bit         held_dbz  = 1'b0;
  bit         check_en  = 1'b0;

  always #5 clk = ~clk;

  mod_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .c           (c),
    .div_by_zero (div_by_zero)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Advance one clock edge and update the model from the inputs seen at that edge.
  task automatic tick();
    bit free;
    @(posedge clk);
    edge_n++;
    if (!rst_n) begin
      pend      = 1'b0;
      held_c    = 10'd0;
      held_dbz  = 1'b0;
      done_at   = -1;
      done_edge = -1;
    end else begin
      free = !pend;
      if (pend && edge_n == done_edge) begin
        held_c   = exp_c;
        held_dbz = exp_dbz;
        pend     = 1'b0;
        done_at  = edge_n;
      end
      if (start && free) begin
        pend      = 1'b1;
        exp_dbz   = (b == 5'd0);
        exp_c     = (b == 5'd0) ? a[9:0] : 10'(a % {12'd0, b});
        done_edge = edge_n + ((b == 5'd0) ? 1 : 18);
      end
    end
    #1;
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (check_en) begin
      check("done", {31'd0, done}, {31'd0, (done_at == edge_n)});
      check("busy", {31'd0, busy}, {31'd0, pend});
      check("c", {22'd0, c}, {22'd0, held_c});
      check("div_by_zero", {31'd0, div_by_zero}, {31'd0, held_dbz});
    end
  end

  // Wait for done with a bound; returns edges counted after the accepting edge.
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (done !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: got no done, expected done within 40 edges");
    end
  endtask

  task automatic op(input logic [16:0] av, input logic [4:0] bv,
                    input logic [9:0] lit_c, input bit lit_dbz, input int lit_lat);
    int n;
    a = av; b = bv; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n);
    check("latency", n, lit_lat);
    check("c_literal", {22'd0, c}, {22'd0, lit_c});
    check("dbz_literal", {31'd0, div_by_zero}, {31'd0, lit_dbz});
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [16:0] sa;
    logic [4:0]  sb;
    rst_n = 1'b0; start = 1'b0; a = 17'd0; b = 5'd0;
    tick();
    tick();
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_c", {22'd0, c}, 32'd0);
    check("reset_dbz", {31'd0, div_by_zero}, 32'd0);
    rst_n = 1'b1;
    check_en = 1'b1;
    tick();

    // a and b incremented alternately over 0..5
    for (int i = 0; i < 11; i++) begin
      sa = 17'((i + 1) / 2);
      sb = 5'(i / 2);
      if (sb == 5'd0) op(sa, sb, sa[9:0], 1'b1, 1);
      else            op(sa, sb, 10'(sa % {12'd0, sb}), 1'b0, 18);
    end
    op(17'd5, 5'd3, 10'd2, 1'b0, 18);
    op(17'd4, 5'd5, 10'd4, 1'b0, 18);
    op(17'd0, 5'd1, 10'd0, 1'b0, 18);

    // extremes
    op(17'd131071, 5'd31, 10'd3, 1'b0, 18);
    op(17'd100000, 5'd7, 10'd5, 1'b0, 18);
    op(17'd131071, 5'd1, 10'd0, 1'b0, 18);

    // divide by zero, then a normal operation clears the flag
    op(17'd1000, 5'd0, 10'd1000, 1'b1, 1);
    op(17'd9, 5'd4, 10'd1, 1'b0, 18);

    // start held high with changing operands while busy
    a = 17'd50; b = 5'd6; start = 1'b1;
    tick();
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      a = 17'($urandom);
      b = 5'($urandom);
      tick();
      n++;
    end
    start = 1'b0;
    check("hold_latency", n, 18);
    check("hold_c", {22'd0, c}, 32'd2);
    repeat (3) tick();

    // reset in the middle of RUN
    a = 17'd1000; b = 5'd7; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_c", {22'd0, c}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    repeat (20) tick();
    op(17'd17, 5'd5, 10'd2, 1'b0, 18);

    // back-to-back: second start raised in the done cycle
    a = 17'd300; b = 5'd11; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n);
    check("b2b_first_c", {22'd0, c}, 32'd3);
    a = 17'd9; b = 5'd4; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n);
    check("b2b_latency", n, 18);
    check("b2b_second_c", {22'd0, c}, 32'd1);
    repeat (3) tick();

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mod_unit.md
Name: mod_unit

Overview:
- Sequential modulo unit: computes c = a mod b for an unsigned 17-bit dividend and an unsigned 5-bit divisor.
- Uses an iterative restoring shift-subtract loop, one quotient bit per clock.
- Sits as a small arithmetic helper behind a start/done handshake; the quotient is computed internally but not exported.
- Interface: one clock; reset is synchronous and active-low. Ports are clk and rst_n.

Parameters:
- A_W, 17, dividend width.
- B_W, 5, divisor width.
- C_W, 10, result width. Must satisfy C_W >= B_W; the remainder is zero-extended to C_W.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  request pulse; sampled only when busy=0.
- a  in  A_W  dividend, captured on accepted start.
- b  in  B_W  divisor, captured on accepted start.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse; c is valid from this cycle on.
- c  out  C_W  remainder, held until the next done.
- div_by_zero  out  1  status of the last completed operation; updated with done.

Behaviour:
- Reset (rst_n=0 at a rising edge): FSM goes to IDLE; busy=0, done=0, c=0, div_by_zero=0, internal registers cleared. Reset mid-operation aborts the operation with no done pulse.
- FSM states:
  - IDLE: start=1 captures a and b.
    - b!=0: go to RUN; remainder register=0; bit counter=A_W-1; busy=1 from the next cycle.
    - b==0: go to FIN.
  - RUN: each edge, rem = {rem, a[msb-first bit]} (B_W+1 bits wide). If rem >= b, subtract b. Decrement the counter. After the A_W-th iteration, go to FIN.
  - FIN: one cycle. done=1; c loads the zero-extended remainder; div_by_zero loads (b==0); busy=0; next state IDLE.
- Latency:
  - b!=0: start sampled at edge N; iterations run on edges N+1..N+17; done is high in the cycle following edge N+18.
  - b==0: done is high in the cycle following edge N+1.
- Divide by zero: c = a[C_W-1:0] (truncated dividend); div_by_zero=1.
- start while busy (RUN or FIN): ignored, no queuing. The captured a and b are unaffected by input changes after capture.
- Back-to-back operation: start may be asserted in the cycle done=1 (state IDLE follows FIN); it is accepted on that cycle's closing edge.
- Arithmetic: unsigned only. The remainder is always < b <= 31, so the upper C_W-B_W bits of c are 0 for b!=0.
- Outputs are fully registered; there is no combinational path from inputs to outputs.

Decomposition:
- Package mod_unit_pkg:
  - A_W, B_W, C_W defaults.
  - State enum {IDLE, RUN, FIN}.
  - Counter width localparam $clog2(A_W).
- Optional sub-module mod_unit_step: combinational single restoring step (rem_in, bit_in, b) -> rem_out. Everything else stays in mod_unit.

Test Plan:
- Sweep, with a and b incremented alternately, covering a=0..5 and b=0..5: for b!=0, c == a mod b (e.g. a=5,b=3 -> c=2; a=4,b=5 -> c=4; a=0,b=1 -> c=0), div_by_zero=0, done exactly 18 edges after start.
- Extremes: a=131071,b=31 -> c=3; a=100000,b=7 -> c=5; a=131071,b=1 -> c=0.
- Divide by zero: a=1000,b=0 -> done after 1 edge, c=1000, div_by_zero=1. A following a=9,b=4 -> c=1, div_by_zero=0.
- start held high during busy with changing a and b: the result matches the originally captured operands; exactly one done per accepted start.
- rst_n low mid-RUN: next cycle busy=0, c=0, no done pulse. A fresh start (a=17,b=5) then yields c=2.
- Back-to-back: start asserted in the done cycle is accepted; the second result appears 18 edges later.
